dcache_store_buffer: RTL and testbench

Posted-write store buffer between the L1 data-cache controller's store port and the memory store interface. Accepts byte-enabled 64-bit stores, answers with a one-cycle completion, and drains them in order to memory over a valid/ack handshake. It back-pressures the cache when full, and it reports address hits so a load-miss refill can be held behind buffered stores. It also supports a flush for cache flush / scratch-mode transitions.

---
 rtl/dcache_sb_pkg.sv | 27 ++
 rtl/dcache_sb_match.sv | 31 +++
 rtl/dcache_store_buffer.sv | 126 ++++++++++++
 tb/tb_dcache_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_sb_pkg.sv
// Shared sizing, pointer and entry types for the dcache store buffer.
// Optional store coalescing is selected by DCACHE_SB_COALESCE_EN (see dcache_store_buffer).
`ifndef DCACHE_ST_ADDR_BITS
`define DCACHE_ST_ADDR_BITS 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 64
`endif

package dcache_sb_pkg;
  localparam int SB_DEPTH  = 4;
  localparam int DEPTH_LOG = $clog2(SB_DEPTH);
  localparam int SB_ADDR_W = `DCACHE_ST_ADDR_BITS;
  localparam int SB_DATA_W = `SIZE_DATA;
  localparam int SB_BE_W   = SB_DATA_W / 8;

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  // One extra bit so a full buffer (count == DEPTH) is representable.
  typedef logic [DEPTH_LOG:0]   cnt_t;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   byteEn;
  } entry_t;
endpackage

// File: rtl/dcache_sb_match.sv
// DEPTH-way address comparator: probe hit vector for load refills and,
// when DCACHE_SB_COALESCE_EN is defined, the youngest-entry store match.
module dcache_sb_match
  import dcache_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic [DEPTH-1:0]  validVec,
  input  logic [ADDR_W-1:0] addrVec [DEPTH],
  input  logic [ADDR_W-1:0] probeAddr,
`ifdef DCACHE_SB_COALESCE_EN
  input  logic [ADDR_W-1:0] stAddr,
  input  ptr_t              youngest,
  output logic              youngestMatch,
`endif
  output logic [DEPTH-1:0]  hitVec
);

  always_comb begin
    hitVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hitVec[i] = validVec[i] && (addrVec[i] == probeAddr);
    end
  end

`ifdef DCACHE_SB_COALESCE_EN
  assign youngestMatch = validVec[youngest] && (addrVec[youngest] == stAddr);
`endif

endmodule

// File: rtl/dcache_store_buffer.sv
// Posted-write store buffer between the L1 dcache store port and memory.
// Define DCACHE_SB_COALESCE_EN to merge stores into the youngest non-head entry.
module dcache_store_buffer
  import dcache_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   stAddr_i,
  input  logic [DATA_W-1:0]   stData_i,
  input  logic [DATA_W/8-1:0] stByteEn_i,
  input  logic                stValid_i,
  output logic                stStall_o,
  output logic                stComplete_o,
  output logic [ADDR_W-1:0]   sb2memStAddr_o,
  output logic [DATA_W-1:0]   sb2memStData_o,
  output logic [DATA_W/8-1:0] sb2memStByteEn_o,
  output logic                sb2memStValid_o,
  input  logic                mem2sbStAck_i,
  input  logic [ADDR_W-1:0]   ldProbeAddr_i,
  output logic                ldProbeHit_o,
  input  logic                flush_i,
  output logic                flushDone_o,
  output logic                empty_o
);

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  entry_t            mem [DEPTH];
  ptr_t              head;
  ptr_t              tail;
  cnt_t              count;
  logic [DEPTH-1:0]  validVec;
  logic [DEPTH-1:0]  hitVec;
  logic [ADDR_W-1:0] addrVec [DEPTH];
  logic              accept;
  logic              push;
  logic              pop;
  logic              merge;
  logic              stCompleteQ;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      validVec[i] = mem[i].valid;
      addrVec[i]  = mem[i].addr;
    end
  end

  // Stall uses the pre-edge count, so a same-cycle pop at full never admits a push.
  assign stStall_o        = (count == FULL_CNT) | flush_i;
  assign accept           = stValid_i & ~stStall_o;
  assign sb2memStValid_o  = (count != '0);
  assign pop              = mem2sbStAck_i & sb2memStValid_o;
  assign sb2memStAddr_o   = mem[head].addr;
  assign sb2memStData_o   = mem[head].data;
  assign sb2memStByteEn_o = mem[head].byteEn;
  assign empty_o          = (count == '0);
  assign flushDone_o      = flush_i & empty_o;
  assign ldProbeHit_o     = |hitVec;
  assign stComplete_o     = stCompleteQ;

`ifdef DCACHE_SB_COALESCE_EN
  ptr_t              youngest;
  logic              youngestMatch;
  logic [DATA_W-1:0] mergedData;

  assign youngest = tail - 1'b1;
  // count >= 2 keeps the merge target off the head, whose fields must stay stable until ack.
  assign merge    = accept & youngestMatch & (count >= cnt_t'(2));

  always_comb begin
    mergedData = mem[youngest].data;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (stByteEn_i[b]) mergedData[8*b +: 8] = stData_i[8*b +: 8];
    end
  end
`else
  assign merge = 1'b0;
`endif

  assign push = accept & ~merge;

  dcache_sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) uMatch (
    .validVec      (validVec),
    .addrVec       (addrVec),
    .probeAddr     (ldProbeAddr_i),
`ifdef DCACHE_SB_COALESCE_EN
    .stAddr        (stAddr_i),
    .youngest      (youngest),
    .youngestMatch (youngestMatch),
`endif
    .hitVec        (hitVec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      stCompleteQ <= 1'b0;
    end else begin
      stCompleteQ <= accept;
      if (pop) begin
        mem[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        mem[tail] <= '{valid: 1'b1, addr: stAddr_i, data: stData_i, byteEn: stByteEn_i};
        tail      <= tail + 1'b1;
      end
`ifdef DCACHE_SB_COALESCE_EN
      if (merge) begin
        mem[youngest].data   <= mergedData;
        mem[youngest].byteEn <= mem[youngest].byteEn | stByteEn_i;
      end
`endif
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed self-checking bench for dcache_store_buffer with a FIFO scoreboard
// of expected memory-side stores; follows DCACHE_SB_COALESCE_EN for merge behaviour.
module tb_dcache_store_buffer;
  import dcache_sb_pkg::*;

  typedef struct {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   en;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [SB_ADDR_W-1:0] stAddr;
  logic [SB_DATA_W-1:0] stData;
  logic [SB_BE_W-1:0]   stByteEn;
  logic                 stValid;
  logic                 stStall_o;
  logic                 stComplete_o;
  logic [SB_ADDR_W-1:0] sb2memStAddr_o;
  logic [SB_DATA_W-1:0] sb2memStData_o;
  logic [SB_BE_W-1:0]   sb2memStByteEn_o;
  logic                 sb2memStValid_o;
  logic                 ack;
  logic [SB_ADDR_W-1:0] ldProbeAddr;
  logic                 ldProbeHit_o;
  logic                 flush;
  logic                 flushDone_o;
  logic                 empty_o;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dcache_store_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .stAddr_i         (stAddr),
    .stData_i         (stData),
    .stByteEn_i       (stByteEn),
    .stValid_i        (stValid),
    .stStall_o        (stStall_o),
    .stComplete_o     (stComplete_o),
    .sb2memStAddr_o   (sb2memStAddr_o),
    .sb2memStData_o   (sb2memStData_o),
    .sb2memStByteEn_o (sb2memStByteEn_o),
    .sb2memStValid_o  (sb2memStValid_o),
    .mem2sbStAck_i    (ack),
    .ldProbeAddr_i    (ldProbeAddr),
    .ldProbeHit_o     (ldProbeHit_o),
    .flush_i          (flush),
    .flushDone_o      (flushDone_o),
    .empty_o          (empty_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [SB_ADDR_W-1:0] a, input logic [SB_DATA_W-1:0] d,
                       input logic [SB_BE_W-1:0] e, input logic ak, input logic fl,
                       input logic [SB_ADDR_W-1:0] probe);
    stValid = v; stAddr = a; stData = d; stByteEn = e;
    ack = ak; flush = fl; ldProbeAddr = probe;
  endtask

  // Check outputs against the model, predict the edge, advance one clock, check completion.
  task automatic cycle();
    logic expStall, acc, pop, mrg, hit;
    int   n;
    exp_t t;
    #1;
    n = sbq.size();
    expStall = (n == SB_DEPTH) || flush;
    check("stall", stStall_o, expStall);
    check("empty", empty_o, n == 0);
    check("memValid", sb2memStValid_o, n != 0);
    check("flushDone", flushDone_o, flush && (n == 0));
    hit = 1'b0;
    foreach (sbq[i]) if (sbq[i].addr == ldProbeAddr) hit = 1'b1;
    check("probeHit", ldProbeHit_o, hit);
    if (n > 0) begin
      check("headAddr", sb2memStAddr_o, sbq[0].addr);
      check("headData", sb2memStData_o, sbq[0].data);
      check("headEn", sb2memStByteEn_o, sbq[0].en);
    end
    acc = stValid && !expStall;
    pop = ack && (n != 0);
    mrg = 1'b0;
`ifdef DCACHE_SB_COALESCE_EN
    if (acc && n >= 2 && sbq[n-1].addr == stAddr) begin
      mrg = 1'b1;
      t = sbq[n-1];
      for (int b = 0; b < SB_BE_W; b++) begin
        if (stByteEn[b]) t.data[8*b +: 8] = stData[8*b +: 8];
      end
      t.en = t.en | stByteEn;
      sbq[n-1] = t;
    end
`endif
    if (pop) void'(sbq.pop_front());
    if (acc && !mrg) begin
      t.addr = stAddr; t.data = stData; t.en = stByteEn;
      sbq.push_back(t);
    end
    @(posedge clk);
    #1;
    check("complete", stComplete_o, acc);
  endtask

  task automatic idle(input logic ak);
    drive(1'b0, '0, '0, '0, ak, 1'b0, '0);
    cycle();
  endtask

  task automatic store(input logic [SB_ADDR_W-1:0] a, input logic [SB_DATA_W-1:0] d,
                       input logic [SB_BE_W-1:0] e, input logic ak);
    drive(1'b1, a, d, e, ak, 1'b0, '0);
    cycle();
  endtask

  initial begin
    // Reset values, including the flush-dependent outputs.
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    #12;
    check("rstStall", stStall_o, 1'b0);
    check("rstValid", sb2memStValid_o, 1'b0);
    check("rstEmpty", empty_o, 1'b1);
    check("rstHit", ldProbeHit_o, 1'b0);
    check("rstComplete", stComplete_o, 1'b0);
    check("rstFlushDone", flushDone_o, 1'b0);
    flush = 1'b1;
    #1;
    check("rstFlushStall", stStall_o, 1'b1);
    check("rstFlushDone1", flushDone_o, 1'b1);
    flush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ack with nothing valid is ignored.
    idle(1'b1);

    // Fill to full; a fifth store is refused.
    for (int i = 0; i < 4; i++) store(SB_ADDR_W'(32'h10 + i), SB_DATA_W'(64'h1000 + i), 8'hFF, 1'b0);
    store(SB_ADDR_W'(32'h14), SB_DATA_W'(64'h1004), 8'hFF, 1'b0);

    // Full: pop and push in the same cycle -> push refused, then accepted next cycle.
    store(SB_ADDR_W'(32'h14), SB_DATA_W'(64'h1004), 8'hFF, 1'b1);
    store(SB_ADDR_W'(32'h14), SB_DATA_W'(64'h1004), 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Load probe hit and its clearing after the ack.
    store(SB_ADDR_W'(32'h20), SB_DATA_W'(64'h11223344), 8'h0F, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, SB_ADDR_W'(32'h20)); cycle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, SB_ADDR_W'(32'h21)); cycle();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, SB_ADDR_W'(32'h20)); cycle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, SB_ADDR_W'(32'h20)); cycle();

    // Coalescing pattern (merges only when the feature is built in).
    store(SB_ADDR_W'(32'h30), SB_DATA_W'(64'hAA), 8'h01, 1'b0);
    store(SB_ADDR_W'(32'h40), SB_DATA_W'(64'hBB), 8'h01, 1'b0);
    store(SB_ADDR_W'(32'h40), SB_DATA_W'(64'hCC00), 8'h02, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, SB_ADDR_W'(32'h40)); cycle();
    // Same address again at count 1 (head only): never merged into the head.
    idle(1'b1);
    store(SB_ADDR_W'(32'h40), SB_DATA_W'(64'hDD0000), 8'h04, 1'b0);
    while (sbq.size() != 0) idle(1'b1);

    // Flush with three entries, acking every cycle while a store is held.
    for (int i = 0; i < 3; i++) store(SB_ADDR_W'(32'h50 + i), SB_DATA_W'(64'h5000 + i), 8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, SB_ADDR_W'(32'h99), SB_DATA_W'(64'h9999), 8'hFF, 1'b1, 1'b1, '0);
      cycle();
    end
    idle(1'b0);

    // Asynchronous reset with two entries pending.
    store(SB_ADDR_W'(32'h60), SB_DATA_W'(64'h6000), 8'hFF, 1'b0);
    store(SB_ADDR_W'(32'h61), SB_DATA_W'(64'h6001), 8'hFF, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    #1;
    check("midRstValid", sb2memStValid_o, 1'b0);
    check("midRstEmpty", empty_o, 1'b1);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    store(SB_ADDR_W'(32'h77), SB_DATA_W'(64'h7777), 8'h3C, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
